// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with prefetch FIFO toward IF/ID
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [31:0]       imem_instr,
    input  logic              imem_valid,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    logic pop;
    logic push;
    logic space;

    // Outputs are forced low during reset so nothing leaks from uninitialised state.
    always_comb begin
        out_valid = rst_n && (count != '0);
        pop       = out_valid && out_ready;
        space     = (count < CW'(DEPTH)) || pop;
        imem_req  = rst_n && !redirect_valid && (state != IDLE) &&
                    ((state == FULL) ? pop : space);
        push      = imem_req && imem_valid;
        imem_addr = (rst_n && state != IDLE) ? pc[ADDR_W+1:2] : '0;
        out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
        out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any push/pop; a head popped this cycle is simply dropped.
            state  <= RUN;
            pc     <= {redirect_pc[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc;
                fifo_instr[wr_ptr] <= imem_instr;
                wr_ptr             <= wr_ptr + PW'(1);
                pc                 <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            if (state == IDLE) begin
                state <= RUN;
            end else begin
                state <= (count_nxt == CW'(DEPTH)) ? FULL : RUN;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector table plus randomized model check of fetch_ctrl
module tb_fetch_ctrl;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  imem_addr;
    logic        imem_req;
    logic [31:0] imem_instr;
    logic        imem_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [9:0] a);
        return {a, 6'h2a, ~a, 6'h15};
    endfunction

    assign imem_instr = rom(imem_addr);

    fetch_ctrl #(.RESET_PC(32'h0), .ADDR_W(10), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_instr(imem_instr), .imem_valid(imem_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        iv;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_req;
        logic [9:0]  e_addr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: program-order queue of fetched {pc, instr} plus a fetch pointer.
    logic [31:0] m_qpc[$];
    logic [31:0] m_qins[$];
    logic [31:0] m_pc;
    logic        m_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic iv, input logic ev,
                       input logic [31:0] epc, input logic ereq, input logic [9:0] eaddr);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.iv = iv;
        v.e_valid = ev; v.e_pc = epc; v.e_req = ereq; v.e_addr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input logic iv);
        rst_n = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy; imem_valid = iv;
    endtask

    task automatic model_step();
        logic m_val, m_req;
        m_val = rst_n && (m_qpc.size() != 0);
        m_req = rst_n && !m_idle && !redirect_valid &&
                ((m_qpc.size() < DEPTH) || (m_val && out_ready));
        if (!rst_n) begin
            m_qpc.delete(); m_qins.delete(); m_pc = 32'h0; m_idle = 1'b1;
        end else if (redirect_valid) begin
            m_qpc.delete(); m_qins.delete(); m_pc = redirect_pc & ~32'h3; m_idle = 1'b0;
        end else begin
            if (m_val && out_ready) begin
                void'(m_qpc.pop_front()); void'(m_qins.pop_front());
            end
            if (m_req && imem_valid) begin
                m_qpc.push_back(m_pc); m_qins.push_back(rom(m_pc[11:2])); m_pc = m_pc + 32'd4;
            end
            m_idle = 1'b0;
        end
    endtask

    task automatic model_check();
        logic        ev, ereq;
        logic [31:0] epc, eins;
        logic [9:0]  eaddr;
        ev    = rst_n && (m_qpc.size() != 0);
        epc   = ev ? m_qpc[0]  : 32'h0;
        eins  = ev ? m_qins[0] : 32'h0;
        ereq  = rst_n && !m_idle && !redirect_valid &&
                ((m_qpc.size() < DEPTH) || (ev && out_ready));
        eaddr = (rst_n && !m_idle) ? m_pc[11:2] : 10'h0;
        check("rnd_out_valid", 32'(out_valid), 32'(ev));
        check("rnd_out_pc",    out_pc,          epc);
        check("rnd_out_instr", out_instr,       eins);
        check("rnd_imem_req",  32'(imem_req),   32'(ereq));
        check("rnd_imem_addr", 32'(imem_addr),  32'(eaddr));
    endtask

    initial begin
        m_pc = 32'h0; m_idle = 1'b1;
        //   rst rv rpc        rdy iv | valid pc        req addr
        add(0, 0, 32'h0,   0, 1,   0, 32'h0,   0, 10'h0);
        add(0, 0, 32'h0,   0, 1,   0, 32'h0,   0, 10'h0);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   0, 10'h0);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   1, 10'h0);
        add(1, 0, 32'h0,   1, 1,   1, 32'h0,   1, 10'h1);
        add(1, 0, 32'h0,   0, 1,   1, 32'h4,   1, 10'h2);
        add(1, 0, 32'h0,   0, 1,   1, 32'h4,   0, 10'h3);
        add(1, 0, 32'h0,   0, 1,   1, 32'h4,   0, 10'h3);
        add(1, 0, 32'h0,   1, 1,   1, 32'h4,   1, 10'h3);
        add(1, 0, 32'h0,   1, 1,   1, 32'h8,   1, 10'h4);
        add(1, 0, 32'h0,   1, 1,   1, 32'hc,   1, 10'h5);
        add(1, 0, 32'h0,   0, 1,   1, 32'h10,  0, 10'h6);
        add(1, 1, 32'h10,  0, 1,   1, 32'h10,  0, 10'h6);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   1, 10'h4);
        add(1, 0, 32'h0,   1, 1,   1, 32'h10,  1, 10'h5);
        add(1, 1, 32'h16,  1, 1,   1, 32'h14,  0, 10'h6);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   1, 10'h5);
        add(1, 1, 32'h20,  1, 1,   1, 32'h14,  0, 10'h6);
        add(1, 1, 32'h40,  1, 1,   0, 32'h0,   0, 10'h8);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   1, 10'h10);
        add(1, 0, 32'h0,   1, 1,   1, 32'h40,  1, 10'h11);
        add(1, 0, 32'h0,   1, 0,   1, 32'h44,  1, 10'h12);
        add(1, 0, 32'h0,   1, 0,   0, 32'h0,   1, 10'h12);
        add(1, 0, 32'h0,   1, 0,   0, 32'h0,   1, 10'h12);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   1, 10'h12);
        add(1, 0, 32'h0,   1, 1,   1, 32'h48,  1, 10'h13);
        add(1, 1, 32'hffc, 1, 1,   1, 32'h4c,  0, 10'h14);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   1, 10'h3ff);
        add(1, 0, 32'h0,   1, 1,   1, 32'hffc, 1, 10'h0);
        add(0, 0, 32'h0,   1, 1,   0, 32'h0,   0, 10'h0);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   0, 10'h0);
        add(1, 0, 32'h0,   1, 1,   0, 32'h0,   1, 10'h0);

        foreach (vecs[i]) begin
            logic [31:0] e_ins;
            drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].iv);
            #1;
            e_ins = vecs[i].e_valid ? rom(vecs[i].e_pc[11:2]) : 32'h0;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_out_pc", i),    out_pc,         vecs[i].e_pc);
            check($sformatf("vec%0d_out_instr", i), out_instr,      e_ins);
            check($sformatf("vec%0d_imem_req", i),  32'(imem_req),  32'(vecs[i].e_req));
            check($sformatf("vec%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
            model_step();
            @(negedge clk);
        end

        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 15) == 0),
                  $urandom(),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) != 0));
            #1;
            model_check();
            model_step();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
